// File: rtl/player_life_manager_pkg.sv
// Shared life-bar parameters, FSM encodings and datapath helpers for the player life block
// and the VGA overlay printers.
package player_life_manager_pkg;

  localparam int          LIFE_W                = 10;
  localparam int          MAX_PLAYER_LIFE_POINT = 100;
  localparam logic [11:0] VGA_RGB_NULL          = 12'h000;

  typedef enum logic [1:0] {
    ST_ALIVE  = 2'd0,
    ST_INVULN = 2'd1,
    ST_DEAD   = 2'd2
  } life_state_e;

  // Damage never wraps below zero.
  function automatic logic [LIFE_W-1:0] sat_sub(input logic [LIFE_W-1:0] a,
                                                input logic [7:0]        b);
    logic [LIFE_W-1:0] bw;
    bw = LIFE_W'(b);
    return (a > bw) ? (a - bw) : '0;
  endfunction

endpackage

// File: rtl/player_life_manager_if.sv
// Event inputs from game logic and life/status outputs towards the VGA overlay.
interface player_life_manager_if;
  import player_life_manager_pkg::*;

  logic              frame_tick;
  logic              restart;
  logic              hit_valid;
  logic [7:0]        hit_damage;
  logic              heal_valid;
  logic [7:0]        heal_amount;
  logic [LIFE_W-1:0] life_point;
  logic              is_dead;
  logic              invuln;
  logic              hit_ack;

  modport master (
    output frame_tick, restart, hit_valid, hit_damage, heal_valid, heal_amount,
    input  life_point, is_dead, invuln, hit_ack
  );

  modport slave (
    input  frame_tick, restart, hit_valid, hit_damage, heal_valid, heal_amount,
    output life_point, is_dead, invuln, hit_ack
  );

endinterface

// File: rtl/player_life_manager_frame_down_counter.sv
// Frame-based down-counter: loadable, decrements on frame_tick, saturates at zero.
module frame_down_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         zero,
  output logic         last
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (tick && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);
  assign last = (count_q == W'(1));

endmodule

// File: rtl/player_life_manager.sv
// Player life owner: hit/heal/regen datapath, ALIVE/INVULN/DEAD FSM and a per-frame
// display latch so the life bar never changes mid-scan.
module player_life_manager
  import player_life_manager_pkg::*;
#(
  parameter int MAX_LIFE      = MAX_PLAYER_LIFE_POINT,
  parameter int START_LIFE    = MAX_PLAYER_LIFE_POINT,
  parameter int INVULN_FRAMES = 60,
  parameter int REGEN_FRAMES  = 120,
  parameter int REGEN_AMOUNT  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  player_life_manager_if.slave  bus
);

  localparam int                INV_W      = $clog2(INVULN_FRAMES + 1);
  localparam int                RGN_W      = $clog2(REGEN_FRAMES + 1);
  localparam int                SUM_W      = LIFE_W + 2;
  localparam logic [LIFE_W-1:0] MAX_L      = LIFE_W'(MAX_LIFE);
  localparam logic [LIFE_W-1:0] START_L    = LIFE_W'(START_LIFE);
  localparam logic [SUM_W-1:0]  REGEN_L    = SUM_W'(REGEN_AMOUNT);
  localparam logic [RGN_W-1:0]  REGEN_LAST = RGN_W'(REGEN_FRAMES - 1);

  life_state_e       state_q, state_d;
  logic [LIFE_W-1:0] life_q, life_d;
  logic [LIFE_W-1:0] life_point_q, life_point_d;
  logic [RGN_W-1:0]  regen_q, regen_d;
  logic              hit_ack_q, hit_ack_d;
  logic              is_dead_q, is_dead_d;
  logic              invuln_q, invuln_d;

  logic              hit_apply, regen_due, inv_zero, inv_last;
  logic [SUM_W-1:0]  sum;
  logic [LIFE_W-1:0] capped, life_res;

  // Heal and regen land first and are clamped, then damage is taken off the clamped value.
  always_comb begin
    hit_apply = (state_q == ST_ALIVE) && bus.hit_valid && (bus.hit_damage != 8'd0);
    regen_due = (state_q == ST_ALIVE) && bus.frame_tick && (regen_q == REGEN_LAST);
    sum = SUM_W'(life_q);
    if (bus.heal_valid && (state_q != ST_DEAD)) begin
      sum = sum + SUM_W'(bus.heal_amount);
    end
    if (regen_due) begin
      sum = sum + REGEN_L;
    end
    capped   = (sum > SUM_W'(MAX_L)) ? MAX_L : sum[LIFE_W-1:0];
    life_res = hit_apply ? sat_sub(capped, bus.hit_damage) : capped;
  end

  frame_down_counter #(.W(INV_W)) u_inv_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (bus.restart),
    .load     (hit_apply && (life_res != '0)),
    .load_val (INV_W'(INVULN_FRAMES)),
    .tick     (bus.frame_tick && (state_q == ST_INVULN)),
    .zero     (inv_zero),
    .last     (inv_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_ALIVE;
      life_q       <= START_L;
      life_point_q <= START_L;
      regen_q      <= '0;
      hit_ack_q    <= 1'b0;
      is_dead_q    <= 1'b0;
      invuln_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      life_q       <= life_d;
      life_point_q <= life_point_d;
      regen_q      <= regen_d;
      hit_ack_q    <= hit_ack_d;
      is_dead_q    <= is_dead_d;
      invuln_q     <= invuln_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.restart) begin
      state_d = ST_ALIVE;
    end else begin
      case (state_q)
        ST_ALIVE:  if (hit_apply) state_d = (life_res == '0) ? ST_DEAD : ST_INVULN;
        ST_INVULN: if (inv_zero || (bus.frame_tick && inv_last)) state_d = ST_ALIVE;
        ST_DEAD:   state_d = ST_DEAD;
        default:   state_d = ST_ALIVE;
      endcase
    end
  end

  // Display latch takes the pre-update life so the bar trails the real value by one frame.
  always_comb begin
    life_d       = life_q;
    life_point_d = life_point_q;
    regen_d      = regen_q;
    hit_ack_d    = 1'b0;
    is_dead_d    = (state_d == ST_DEAD);
    invuln_d     = (state_d == ST_INVULN);
    if (bus.restart) begin
      life_d       = START_L;
      life_point_d = START_L;
      regen_d      = '0;
    end else begin
      life_d    = life_res;
      hit_ack_d = hit_apply;
      if (bus.frame_tick) begin
        life_point_d = life_q;
      end
      if (hit_apply || regen_due) begin
        regen_d = '0;
      end else if ((state_q == ST_ALIVE) && bus.frame_tick) begin
        regen_d = regen_q + RGN_W'(1);
      end
    end
  end

  assign bus.life_point = life_point_q;
  assign bus.is_dead    = is_dead_q;
  assign bus.invuln     = invuln_q;
  assign bus.hit_ack    = hit_ack_q;

endmodule
